// File: rtl/dsp_mac_sequencer_if.sv
// Job, operand and result handshakes between a MAC client and dsp_mac_sequencer.
// The operand data itself goes straight to the slice; only its valid/ready pair lives here.
interface dsp_mac_sequencer_if #(
  parameter int unsigned P_WIDTH   = 48,
  parameter int unsigned LEN_WIDTH = 8
);
  logic                 start_valid;
  logic                 start_ready;
  logic [LEN_WIDTH-1:0] start_len;
  logic                 start_sub;
  logic                 in_valid;
  logic                 in_ready;
  logic                 result_valid;
  logic                 result_ready;
  logic [P_WIDTH-1:0]   result;

  modport master (
    output start_valid, start_len, start_sub, in_valid, result_ready,
    input  start_ready, in_ready, result_valid, result
  );

  modport slave (
    input  start_valid, start_len, start_sub, in_valid, result_ready,
    output start_ready, in_ready, result_valid, result
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Control sequencer running a DSP48A1-style multiply/post-add slice as an N-beat MAC.
// A tag pipeline mirrors the slice's multiply pipeline so ce_p/opmode line up with each product.
module dsp_mac_sequencer #(
  parameter int unsigned P_WIDTH   = 48,
  parameter int unsigned LEN_WIDTH = 8,
  parameter int unsigned PIPE_LAT  = 3
) (
  input  logic               clk,
  input  logic               rst,
  dsp_mac_sequencer_if.slave bus,
  output logic               ce_in,
  output logic               ce_pipe,
  output logic               ce_p,
  output logic [7:0]         opmode,
  input  logic [P_WIDTH-1:0] p_in,
  output logic               busy
);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StCapture, StDone} state_e;

  state_e               state_q;
  logic [PIPE_LAT-1:0]  tag_v_q;
  logic [PIPE_LAT-1:0]  tag_f_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 sub_q;
  logic                 first_q;
  logic [P_WIDTH-1:0]   result_q;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic                 in_ready;

  assign in_ready = (state_q == StRun);
  assign cnt_inc  = cnt_q + 1'b1;

  assign bus.start_ready  = (state_q == StIdle);
  assign bus.in_ready     = in_ready;
  assign bus.result_valid = (state_q == StDone);
  assign bus.result       = result_q;

  assign ce_in   = bus.in_valid & in_ready;
  assign ce_pipe = (state_q == StRun) || (state_q == StDrain);
  assign busy    = (state_q != StIdle);

  // The first beat loads P with Z=0, so a stale P from an aborted job never leaks in.
  assign ce_p   = tag_v_q[PIPE_LAT-1];
  assign opmode = ce_p ? {sub_q, 3'b000, ~tag_f_q[PIPE_LAT-1], 3'b001} : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tag_v_q  <= '0;
      tag_f_q  <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      sub_q    <= 1'b0;
      first_q  <= 1'b0;
      result_q <= '0;
    end else begin
      if (ce_pipe) begin
        tag_v_q <= {tag_v_q[PIPE_LAT-2:0], ce_in};
        tag_f_q <= {tag_f_q[PIPE_LAT-2:0], ce_in & first_q};
      end
      unique case (state_q)
        StIdle: begin
          if (bus.start_valid) begin
            len_q   <= bus.start_len;
            sub_q   <= bus.start_sub;
            cnt_q   <= '0;
            first_q <= 1'b1;
            if (bus.start_len == '0) begin
              result_q <= '0;
              state_q  <= StDone;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (ce_in) begin
            first_q <= 1'b0;
            cnt_q   <= cnt_inc;
            if (cnt_inc == len_q) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // Nothing behind the final stage: the last product lands in P on this edge.
          if (tag_v_q[PIPE_LAT-2:0] == '0) begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          result_q <= p_in;
          state_q  <= StDone;
        end
        StDone: begin
          if (bus.result_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural multiply/post-add slice and a result scoreboard.
module tb_dsp_mac_sequencer;
  localparam int PL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce_in, ce_pipe, ce_p, busy;
  logic [7:0] opmode;
  logic signed [17:0] a_in = '0;
  logic signed [17:0] b_in = '0;
  logic signed [47:0] ab = '0;
  logic signed [47:0] p_model = '0;
  logic signed [47:0] mp [PL-1];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int cin_cnt = 0;
  int cep_cnt = 0;
  int first_cep = -1;
  int va[$];
  int vb[$];
  logic [47:0] exp_res[$];
  logic [7:0]  exp_op[$];

  dsp_mac_sequencer_if #(.P_WIDTH(48), .LEN_WIDTH(8)) bus ();

  dsp_mac_sequencer #(.P_WIDTH(48), .LEN_WIDTH(8), .PIPE_LAT(PL)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .ce_in   (ce_in),
    .ce_pipe (ce_pipe),
    .ce_p    (ce_p),
    .opmode  (opmode),
    .p_in    (p_model),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] slice_next(input logic [7:0] op, input logic [47:0] p,
                                             input logic [47:0] m);
    logic [47:0] x, z;
    x = (op[1:0] == 2'b01) ? m : '0;
    z = (op[3:2] == 2'b10) ? p : '0;
    return op[7] ? z - x : z + x;
  endfunction

  // Behavioural slice: A/B register, PL-1 multiply stages, then P.
  always @(posedge clk) begin
    if (ce_in) ab <= 48'(a_in) * 48'(b_in);
    if (ce_pipe) begin
      mp[0] <= ab;
      for (int k = 1; k < PL - 1; k++) mp[k] <= mp[k-1];
    end
    if (ce_p) p_model <= slice_next(opmode, p_model, mp[PL-2]);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ce_in) cin_cnt++;
        if (ce_p) begin
          cep_cnt++;
          if (first_cep < 0) first_cep = cyc;
          if (exp_op.size() == 0) check_eq("opmode_extra", 64'(opmode), 64'hFFFF);
          else check_eq("opmode", 64'(opmode), 64'(exp_op.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic check_idle(input string tag);
    check_eq({tag, "_start_ready"}, 64'(bus.start_ready), 64'd1);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_result"}, 64'(bus.result), 64'd0);
    check_eq({tag, "_ctl"}, 64'({bus.in_ready, ce_in, ce_pipe, ce_p, opmode, bus.result_valid}),
             64'd0);
  endtask

  task automatic feed(input int n, input int bubble);
    int k;
    for (int i = 0; i < n; i++) begin
      a_in = 18'(va[i]);
      b_in = 18'(vb[i]);
      bus.in_valid = 1'b1;
      k = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        k++;
        if (k > 20) break;
      end
      if (k > 20) begin
        check_eq("accept_timeout", 64'(k), 64'd0);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (bubble != 0 && i < n - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run_job(input string name, input int n, input bit sub, input int bubble,
                         input bit hold);
    longint sum;
    int s;
    int exp_done;
    bit got;
    sum = 0;
    for (int i = 0; i < n; i++) sum += longint'(va[i]) * longint'(vb[i]);
    exp_res.push_back(sub ? 48'(-sum) : 48'(sum));
    for (int i = 0; i < n; i++) exp_op.push_back({sub, 3'b000, (i == 0) ? 1'b0 : 1'b1, 3'b001});
    cin_cnt = 0;
    cep_cnt = 0;
    first_cep = -1;
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.start_len = 8'(n);
    bus.start_sub = sub;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    s = cyc;
    feed(n, bubble);
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.result_valid) begin
        got = 1'b1;
        break;
      end
    end
    check_eq({name, "_rv_seen"}, 64'(got), 64'd1);
    exp_done = (n == 0) ? s : s + n + PL + 1 + ((bubble != 0) ? n - 1 : 0);
    check_eq({name, "_done_cyc"}, 64'(cyc), 64'(exp_done));
    check_eq({name, "_result"}, 64'(bus.result), 64'(exp_res.pop_front()));
    check_eq({name, "_ce_in_cnt"}, 64'(cin_cnt), 64'(n));
    check_eq({name, "_ce_p_cnt"}, 64'(cep_cnt), 64'(n));
    if (n > 0 && bubble == 0) check_eq({name, "_first_ce_p"}, 64'(first_cep), 64'(s + PL));
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        bus.start_valid = 1'b1;
        bus.result_ready = 1'b0;
        @(negedge clk);
        check_eq({name, "_hold_rv"}, 64'(bus.result_valid), 64'd1);
        check_eq({name, "_hold_res"}, 64'(bus.result), 64'(sub ? 48'(-sum) : 48'(sum)));
        check_eq({name, "_hold_sr"}, 64'(bus.start_ready), 64'd0);
      end
      bus.start_valid = 1'b0;
    end
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    @(negedge clk);
    check_eq({name, "_idle_sr"}, 64'(bus.start_ready), 64'd1);
    check_eq({name, "_idle_rv"}, 64'(bus.result_valid), 64'd0);
    check_eq({name, "_op_left"}, 64'(exp_op.size()), 64'd0);
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.start_len = '0;
    bus.start_sub = 1'b0;
    bus.in_valid = 1'b0;
    bus.result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    va = '{1, 3, 5, 7};
    vb = '{2, 4, 6, 8};
    run_job("add", 4, 1'b0, 0, 1'b0);
    run_job("sub", 4, 1'b1, 0, 1'b0);
    bus.in_valid = 1'b1;
    run_job("zero", 0, 1'b0, 0, 1'b0);
    bus.in_valid = 1'b0;
    run_job("bubble", 4, 1'b0, 1, 1'b0);
    run_job("hold", 4, 1'b0, 0, 1'b1);

    // Abort a job after two beats with a reset.
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.start_len = 8'd4;
    bus.start_sub = 1'b0;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    feed(2, 0);
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("abort");
    bus.in_valid = 1'b0;
    exp_op.delete();

    va = '{2, 4};
    vb = '{3, 5};
    run_job("post", 2, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Sequencer that drives one DSP48A1-style multiply/post-add slice as a length-N multiply-accumulate engine. It accepts a job (beat count and add/subtract mode), paces operand acceptance with a valid/ready handshake, and generates the slice's clock enables and OPMODE aligned to each product's arrival at the P register. It then captures the final P value and offers it on a valid/ready result port. Operand data flows from the source straight to the slice's A/B ports; this block carries control only.

## Interface
- P_WIDTH, 48, width of slice P output and of `result`
- LEN_WIDTH, 8, width of beat count
- PIPE_LAT, 3, edges from operand capture (`ce_in` edge) to the P-register update with that product; legal range 2..8

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  job request
- start_ready  out  1  high only in IDLE
- start_len  in  LEN_WIDTH  number of operand beats N
- start_sub  in  1  1: result = -sum of products; 0: +sum
- in_valid  in  1  operand pair present at slice A/B inputs
- in_ready  out  1  high only in RUN
- ce_in  out  1  A/B input-register enable = in_valid & in_ready
- ce_pipe  out  1  internal pipeline (M, B1 etc.) enable; high in RUN and DRAIN
- ce_p  out  1  P-register enable; high only when a valid tag is at the last stage
- opmode  out  8  slice OPMODE for the current P update
- p_in  in  P_WIDTH  slice P output
- result_valid  out  1  final result available
- result_ready  in  1  result consumer accepts
- result  out  P_WIDTH  captured accumulation result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RUN, DRAIN, CAPTURE, DONE.
- IDLE: start handshake latches N and sub, clears the beat counter and first-beat flag. N=0 goes to DONE with result=0. N>0 goes to RUN.
- RUN: each accepted beat sets a tag (valid, first) at stage 0 of a PIPE_LAT-deep tag shift register. The register shifts every cycle in RUN/DRAIN, so bubbles propagate as invalid tags. After beat N is accepted, go to DRAIN; in_ready is low from the next cycle.
- DRAIN: stay until the last valid tag leaves the final stage, i.e., the edge where P captures product N. Then go to CAPTURE.
- CAPTURE: one cycle. At its closing edge `result <= p_in`; go to DONE.
- DONE: result_valid=1 and result stable until result_ready. On that edge go to IDLE.
- Final-stage tag drives ce_p=1 and opmode:
  - first beat: 8'h01 (X=M, Z=0), or 8'h81 if sub.
  - later beats: 8'h09 (X=M, Z=P), or 8'h89 if sub.
  - no valid tag at final stage: ce_p=0, opmode=8'h00.
- Arithmetic is performed by the slice. The block does not check overflow; result is the raw P_WIDTH two's-complement value.
- Reset (any state, including mid-RUN/DRAIN): state=IDLE, tags cleared, counter=0, result=0. Every output is 0 except start_ready=1. Any partial slice P value is abandoned; the next job's first beat uses Z=0, so no P reset is needed.

## Timing
- Start edge S; in_ready high from cycle after S.
- No bubbles: beats accepted at edges S+1..S+N; ce_p high in the cycles before edges S+1+PIPE_LAT..S+N+PIPE_LAT.
- Capture at edge S+N+PIPE_LAT+1; result_valid high in the following cycle. Latency from last beat to result_valid is PIPE_LAT+1 edges.
- N=0: result_valid high in the cycle after S; ce_in/ce_p never asserted.
- in_valid bubbles delay completion by exactly the bubble count; ce_p pulses exactly N times per job.
- start_valid in any state but IDLE is ignored. in_valid outside RUN is ignored (ce_in=0).
- result_valid and result_ready high on the same edge returns to IDLE. start_ready rises the next cycle; no same-cycle restart.

## Test plan
- PIPE_LAT=3, N=4, pairs (1,2),(3,4),(5,6),(7,8), sub=0, with a behavioural slice model -> result=100; result_valid after edge S+8; ce_p pulses 4 times; opmode sequence 01,09,09,09.
- Same operands with sub=1 -> result=48'hFFFF_FFFF_FF9C (-100); opmode 81,89,89,89.
- N=0 -> result_valid in cycle after S, result=0, zero ce_in/ce_p pulses.
- N=4 with in_valid low 1 cycle between every beat -> result=100, completion 3 cycles later than the no-bubble case.
- result_ready held low 5 cycles -> result and result_valid stable, start_ready=0, start_valid ignored; then result_ready=1 -> IDLE the next cycle.
- rst asserted after 2 of 4 beats -> next cycle all outputs 0, start_ready=1. A following N=2 job with (2,3),(4,5) -> result=26.
